rpll_lock_sequencer: RTL
========================

// Module: rpll_lock_sequencer
// PURPOSE
//  Supervises a Gowin rPLL from its free-running input-clock domain: pulses the PLL RESET, waits for
//  LOCK with timeout and bounded retries, qualifies lock stability, then releases NUM_CHANNELS
//  downstream reset lines in a staggered sequence. Re-sequences on lock loss or a forced restart.
//  Sits between the rPLL wrapper and the per-domain reset synchronisers (DDR3 PHY, AXI, user logic).
// PARAMETERS
//  NUM_CHANNELS  3    number of sequenced reset outputs (1..16)
//  RESET_CYCLES  4    cycles pll_reset_o held high per attempt (>=1)
//  LOCK_TIMEOUT  64   cycles allowed in WAIT for lock before a retry (>=2)
//  LOCK_STABLE   16   consecutive synchronised-lock cycles required before release (>=1)
//  STAGGER       8    cycles between successive channel releases (>=1)
//  MAX_RETRIES   3    failed attempts before FAULT (>=1)
// PORTS
//  clock          in   1     free-running PLL reference clock
//  reset_n        in   1     asynchronous active-low reset
//  pll_lock_i     in   1     rPLL LOCK, asynchronous to clock
//  force_i        in   1     synchronous restart request, level, sampled every cycle
//  pll_reset_o    out  1     drives rPLL RESET, active-high
//  rst_n_o        out  NC    per-channel active-low resets, bit k released k-th
//  locked_o       out  1     high once lock qualified, until lock lost/restart
//  fault_o        out  1     high in FAULT
//  lost_o         out  1     one-cycle pulse on lock loss after qualification
//  retries_o      out  4     failed attempts in current sequence (saturates at 15)
// BEHAVIOUR
//  - reset_n low: state=RESET, cnt=0, retries=0, pll_reset_o=1, rst_n_o=0, locked_o=0, fault_o=0,
//    lost_o=0. All outputs registered. Sync flops cleared.
//  - pll_lock_i passes a 2-flop synchroniser -> lock_s (2-cycle latency); FSM uses lock_s only.
//  - Single shared counter cnt, width $clog2 of max(RESET_CYCLES,LOCK_TIMEOUT,LOCK_STABLE,
//    NUM_CHANNELS*STAGGER)+1; cleared on every state transition.
//  - RESET: pll_reset_o=1; after RESET_CYCLES cycles -> WAIT (pll_reset_o=0 from that edge).
//  - WAIT: lock_s=1 -> STABLE. cnt==LOCK_TIMEOUT-1 with lock_s=0 -> retries+1; if new value
//    ==MAX_RETRIES -> FAULT else -> RESET. Lock and timeout in same cycle: lock wins.
//  - STABLE: lock_s=0 -> WAIT (timeout restarts, no retry charged). LOCK_STABLE consecutive
//    lock_s=1 cycles -> RELEASE; locked_o=1 on that edge.
//  - RELEASE: rst_n_o[k] goes 1 at the edge ending cycle k*STAGGER after entry (bit 0 on the first
//    edge in RELEASE). Released bits stay 1. After bit NC-1 released -> RUN.
//  - RUN: all rst_n_o=1, locked_o=1; idle until event.
//  - Lock loss (lock_s=0 in RELEASE or RUN): next edge rst_n_o=all 0, locked_o=0, lost_o=1 for one
//    cycle, retries=0, -> RESET.
//  - force_i=1 in any state: next edge -> RESET, rst_n_o=0, locked_o=0, fault_o=0, retries=0,
//    lost_o=0. Held force_i keeps the block in RESET (pll_reset_o=1) with cnt held at 0.
//    force_i has priority over lock loss and timeout in the same cycle.
//  - FAULT: fault_o=1, pll_reset_o=0, rst_n_o=0; exits only via force_i or reset_n.
//  - rst_n_o never glitches high outside RELEASE/RUN; no bit released before all lower bits.
//  - reset_n mid-sequence: immediate return to reset values; no partial release survives.
// TESTING (NC=3, RESET_CYCLES=4, LOCK_TIMEOUT=64, LOCK_STABLE=16, STAGGER=8, MAX_RETRIES=3)
//  1 lock rises 10 cycles after pll_reset_o falls -> locked_o high 2+16 cycles later; rst_n_o
//    bits 0/1/2 rise at +1/+9/+17 cycles after entering RELEASE; reach RUN.
//  2 lock never asserts -> 3 pll_reset_o pulses of 4 cycles each, retries_o 1,2,3, fault_o=1
//    after the third 64-cycle timeout; rst_n_o stays 0; force_i pulse restarts with retries_o=0.
//  3 lock glitches low for 1 cycle at STABLE cnt=10 -> back to WAIT, retries_o unchanged,
//    locked_o rises only after a fresh 16-cycle stable run.
//  4 lock drops in RUN -> next edges: rst_n_o=000, lost_o single pulse, pll_reset_o=1 for 4 cycles,
//    full re-sequence on relock.
//  5 force_i held 20 cycles mid-RELEASE (bit 0 released) -> rst_n_o=000 next edge, pll_reset_o=1
//    for 20+4 cycles, then normal sequence.
//  6 reset_n asserted asynchronously mid-RELEASE -> all outputs at reset values without a clock
//    edge; random lock/force stimulus checks release ordering and no early release.

Source files
------------

// File: rtl/rpll_lock_sequencer.sv
// Supervises a Gowin rPLL: pulses RESET, waits for LOCK with timeout/retries, qualifies
// lock stability, then releases the downstream reset lines one after another.
module rpll_lock_sequencer #(
  parameter int NUM_CHANNELS = 3,
  parameter int RESET_CYCLES = 4,
  parameter int LOCK_TIMEOUT = 64,
  parameter int LOCK_STABLE  = 16,
  parameter int STAGGER      = 8,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    pll_lock_i,
  input  logic                    force_i,
  output logic                    pll_reset_o,
  output logic [NUM_CHANNELS-1:0] rst_n_o,
  output logic                    locked_o,
  output logic                    fault_o,
  output logic                    lost_o,
  output logic [3:0]              retries_o
);

  localparam int MAX_A   = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B   = (LOCK_STABLE > NUM_CHANNELS * STAGGER) ? LOCK_STABLE : NUM_CHANNELS * STAGGER;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'((NUM_CHANNELS - 1) * STAGGER);
  localparam logic [3:0]    RETRY_LIMIT  = 4'((MAX_RETRIES > 15) ? 15 : MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [3:0]              retries_n, retry_inc;
  logic [NUM_CHANNELS-1:0] rst_n_n;
  logic                    lost_n;
  logic                    lock_meta, lock_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock_i;
      lock_s    <= lock_meta;
    end
  end

  assign retry_inc = (retries_o == 4'hF) ? 4'hF : retries_o + 4'd1;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    retries_n = retries_o;
    rst_n_n   = rst_n_o;
    lost_n    = 1'b0;

    if (force_i) begin
      state_n   = S_RESET;
      retries_n = 4'd0;
    end else begin
      case (state)
        S_RESET: begin
          if (cnt == RESET_LAST) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (lock_s) begin
            state_n = S_STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            retries_n = retry_inc;
            state_n   = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_RESET;
          end
        end
        S_STABLE: begin
          // Lock must be seen for LOCK_STABLE consecutive cycles while in STABLE.
          if (!lock_s) state_n = S_WAIT;
          else if (cnt == STABLE_LAST) state_n = S_RELEASE;
        end
        S_RELEASE: begin
          if (!lock_s) begin
            state_n   = S_RESET;
            lost_n    = 1'b1;
            retries_n = 4'd0;
          end else begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
              if (cnt == CW'(k * STAGGER)) rst_n_n[k] = 1'b1;
            end
            if (cnt == RELEASE_LAST) state_n = S_RUN;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_n   = S_RESET;
            lost_n    = 1'b1;
            retries_n = 4'd0;
          end
        end
        S_FAULT: begin
          state_n = S_FAULT;
        end
        default: begin
          state_n = S_RESET;
        end
      endcase
    end

    if (force_i || (state_n != state) || (state == S_RUN) || (state == S_FAULT)) cnt_n = '0;
    // Channel resets may only be released while in RELEASE or RUN.
    if ((state_n != S_RELEASE) && (state_n != S_RUN)) rst_n_n = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_RESET;
      cnt         <= '0;
      retries_o   <= 4'd0;
      rst_n_o     <= '0;
      pll_reset_o <= 1'b1;
      locked_o    <= 1'b0;
      fault_o     <= 1'b0;
      lost_o      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      retries_o   <= retries_n;
      rst_n_o     <= rst_n_n;
      pll_reset_o <= (state_n == S_RESET);
      locked_o    <= (state_n == S_RELEASE) || (state_n == S_RUN);
      fault_o     <= (state_n == S_FAULT);
      lost_o      <= lost_n;
    end
  end

endmodule
